// File: rtl/detect_mon_pkg.sv
// Shared types and helpers for the detector event monitor.
package detect_mon_pkg;

  typedef enum logic [1:0] {M_IDLE, M_WINDOW, M_ALARM} mon_state_t;

  // Increment that holds at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Timestamp FIFO; accepts push and pop in the same cycle even when full.
module ts_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q, level_d;
  logic            do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  // Storage is not reset, so mask the head while empty.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/detect_event_monitor.sv
// Timestamps detector pulses into a FIFO, counts/drops them and raises a windowed
// threshold alarm.
module detect_event_monitor
  import detect_mon_pkg::*;
#(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIN    = 64,
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   detect,
  input  logic                   evt_ready,
  input  logic                   alarm_clr,
  input  logic                   stat_clr,
  output logic                   evt_valid,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   alarm,
  output logic                   overflow,
  output logic [CNT_W-1:0]       event_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned WIN_W    = $clog2(WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
  localparam logic [7:0]       THRESH_B = 8'(THRESH);

  logic [TS_W-1:0]  ts_q;
  logic             full, empty, pop, push, drop;
  mon_state_t       state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]       hits_q, hits_d;

  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign push      = detect && (!full || pop);
  assign drop      = detect && full && !pop;
  assign alarm     = (state_q == M_ALARM);

  ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ts_q),
    .dout  (evt_ts),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q        <= '0;
      overflow    <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      // A clear outranks any increment landing in the same cycle.
      if (stat_clr) begin
        overflow    <= 1'b0;
        event_count <= '0;
        drop_count  <= '0;
      end else begin
        if (detect) event_count <= CNT_W'(sat_inc(32'(event_count), CNT_W));
        if (drop) begin
          overflow   <= 1'b1;
          drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    hits_d    = hits_q;
    case (state_q)
      M_IDLE: begin
        if (detect) begin
          win_cnt_d = '0;
          hits_d    = 8'd1;
          state_d   = (THRESH == 1) ? M_ALARM : M_WINDOW;
        end
      end
      M_WINDOW: begin
        if (detect && (hits_q + 8'd1 == THRESH_B)) begin
          state_d = M_ALARM;
        end else if (win_cnt_q == WIN_LAST) begin
          if (detect) begin
            win_cnt_d = '0;
            hits_d    = 8'd1;
          end else begin
            state_d = M_IDLE;
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (detect) hits_d = hits_q + 8'd1;
        end
      end
      M_ALARM: begin
        if (alarm_clr) begin
          if (detect) begin
            state_d   = M_WINDOW;
            win_cnt_d = '0;
            hits_d    = 8'd1;
          end else begin
            state_d = M_IDLE;
          end
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= M_IDLE;
      win_cnt_q <= '0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      hits_q    <= hits_d;
    end
  end

`ifdef ASSERTIONS
  always @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown({evt_valid, evt_ts, fifo_level, alarm, overflow,
                           event_count, drop_count}));
      assert (fifo_level <= ($clog2(DEPTH)+1)'(DEPTH));
      assert (alarm == (state_q == M_ALARM));
      assert (!(push && full && !pop));
    end
  end
`endif

endmodule
